// File: rtl/instr_decode_stage.sv
// Instruction decode stage: decodes each accepted 32-bit word into its fields and queues the result in a DEPTH-entry buffer.
// Optional build macro DECODE_ILLEGAL_EN: restricts DS to opcodes 58/62 and flags every other unlisted opcode as illegal (fmt=6).
module instr_decode_stage #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      po,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      bo,
    output logic [4:0]      bi,
    output logic            aa,
    output logic            lk,
    output logic            rc,
    output logic            oe,
    output logic [9:0]      xox,
    output logic [8:0]      xoxo,
    output logic [15:0]     si,
    output logic [13:0]     bd,
    output logic [XLEN-1:0] ds,
    output logic [1:0]      xods,
    output logic [23:0]     li,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [2:0] FMT_XO  = 3'd0;
    localparam logic [2:0] FMT_X   = 3'd1;
    localparam logic [2:0] FMT_D   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_I   = 3'd4;
    localparam logic [2:0] FMT_DS  = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd6;

    typedef struct packed {
        logic [5:0]      po;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      bo;
        logic [4:0]      bi;
        logic            aa;
        logic            lk;
        logic            rc;
        logic            oe;
        logic [9:0]      xox;
        logic [8:0]      xoxo;
        logic [15:0]     si;
        logic [13:0]     bd;
        logic [XLEN-1:0] ds;
        logic [1:0]      xods;
        logic [23:0]     li;
        logic [2:0]      fmt;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t             buf_q [DEPTH];
    entry_t             dec_d;
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;
    logic [5:0]         op;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign op = instruction[31:26];

    always_comb begin
        dec_d    = '0;
        dec_d.po = op;
        dec_d.pc = pc_in;
        if (op == 6'd31) begin
            dec_d.rd = instruction[25:21];
            dec_d.rs = instruction[20:16];
            dec_d.rt = instruction[15:11];
            dec_d.rc = instruction[0];
            if (instruction[9:1] == 9'd266 || instruction[9:1] == 9'd40) begin
                dec_d.fmt  = FMT_XO;
                dec_d.oe   = instruction[10];
                dec_d.xoxo = instruction[9:1];
            end else begin
                dec_d.fmt = FMT_X;
                dec_d.xox = instruction[10:1];
            end
        end else if (op inside {6'd14, 6'd15, 6'd24, 6'd26, 6'd28, 6'd32, 6'd34,
                                6'd36, 6'd37, 6'd38, 6'd40, 6'd42, 6'd44}) begin
            dec_d.fmt = FMT_D;
            dec_d.rd  = instruction[25:21];
            dec_d.rs  = instruction[20:16];
            dec_d.si  = instruction[15:0];
            dec_d.ds  = {{(XLEN-16){instruction[15]}}, instruction[15:0]};
        end else if (op == 6'd19) begin
            dec_d.fmt = FMT_B;
            dec_d.bo  = instruction[25:21];
            dec_d.bi  = instruction[20:16];
            dec_d.bd  = instruction[15:2];
            dec_d.aa  = instruction[1];
            dec_d.lk  = instruction[0];
        end else if (op == 6'd18) begin
            dec_d.fmt = FMT_I;
            dec_d.li  = instruction[25:2];
            dec_d.aa  = instruction[1];
            dec_d.lk  = instruction[0];
`ifdef DECODE_ILLEGAL_EN
        end else if (op != 6'd58 && op != 6'd62) begin
            dec_d.fmt     = FMT_ILL;
            dec_d.illegal = 1'b1;
`endif
        end else begin
            // DS displacement is kept word-granular: no shift back by two.
            dec_d.fmt  = FMT_DS;
            dec_d.rd   = instruction[25:21];
            dec_d.rs   = instruction[20:16];
            dec_d.ds   = {{(XLEN-14){instruction[15]}}, instruction[15:2]};
            dec_d.xods = instruction[1:0];
        end
    end

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                buf_q[wr_ptr_q] <= dec_d;
            end
        end
    end

    assign head    = buf_q[rd_ptr_q];
    assign po      = head.po;
    assign rs      = head.rs;
    assign rt      = head.rt;
    assign rd      = head.rd;
    assign bo      = head.bo;
    assign bi      = head.bi;
    assign aa      = head.aa;
    assign lk      = head.lk;
    assign rc      = head.rc;
    assign oe      = head.oe;
    assign xox     = head.xox;
    assign xoxo    = head.xoxo;
    assign si      = head.si;
    assign bd      = head.bd;
    assign ds      = head.ds;
    assign xods    = head.xods;
    assign li      = head.li;
    assign fmt     = head.fmt;
    assign pc_out  = head.pc;
    assign illegal = head.illegal;

endmodule
